// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer: cuts an untagged AXI-Stream byte stream into packets.
// A packet closes after MAX_PKT_LEN bytes or after IDLE_TIMEOUT idle cycles
// with a byte held. A one-word hold register lets the closing byte be tagged
// with tlast without inserting a bubble.
// Build option: define AXIS_PKT_CHECKSUM_EN to append an XOR trailer beat
// (tlast=1) after the last payload byte of every packet.
module axis_pkt_framer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_PKT_LEN  = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  pkt_done
);

  localparam int unsigned       CNT_W    = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam int unsigned       IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  committed_q, committed_d;
  logic                  done_q, done_d;

  logic                  force_last;
  logic                  trailer;
  logic                  close_tag;
  logic [DATA_WIDTH-1:0] trl_data;
  logic                  out_valid, out_last, out_hs, payload_hs;
  logic                  in_ready, in_hs;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  unused_tlast;

  // Input stream is untagged; its tlast carries no information.
  assign unused_tlast = s_axis_tlast;

  assign force_last = (pkt_cnt_q == CNT_LAST) | (idle_cnt_q == IDLE_MAX);

`ifdef AXIS_PKT_CHECKSUM_EN
  typedef enum logic {ST_PAYLOAD, ST_TRAILER} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] xor_q, xor_d;

  assign trailer   = (state_q == ST_TRAILER);
  assign trl_data  = xor_q;
  // The closing payload byte is untagged; the trailer beat carries tlast.
  assign close_tag = 1'b0;

  // Checksum accumulation and payload/trailer sequencing
  always_comb begin
    state_d = state_q;
    xor_d   = xor_q;
    if (payload_hs) begin
      xor_d = xor_q ^ hold_q;
      if (force_last) state_d = ST_TRAILER;
    end else if (trailer && out_hs) begin
      xor_d   = '0;
      state_d = ST_PAYLOAD;
    end
  end

  // Checksum FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PAYLOAD;
      xor_q   <= '0;
    end else begin
      state_q <= state_d;
      xor_q   <= xor_d;
    end
  end
`else
  assign trailer   = 1'b0;
  assign trl_data  = '0;
  assign close_tag = force_last;
`endif

  // Output beat selection and both handshakes
  always_comb begin
    if (trailer) begin
      out_valid = 1'b1;
      out_data  = trl_data;
      out_last  = 1'b1;
    end else begin
      // Once offered (committed), valid must persist until the handshake.
      out_valid = hold_valid_q & (committed_q | s_axis_tvalid | force_last);
      out_data  = hold_q;
      out_last  = close_tag;
    end
    out_hs     = out_valid & m_axis_tready;
    payload_hs = out_hs & ~trailer;
    // A payload handshake frees the hold in the same cycle, giving full rate.
    in_ready   = ~hold_valid_q | payload_hs;
    in_hs      = s_axis_tvalid & in_ready;
  end

  // Next-state for hold register, counters and done pulse
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (in_hs) begin
      hold_d       = s_axis_tdata;
      hold_valid_d = 1'b1;
    end else if (payload_hs) begin
      hold_valid_d = 1'b0;
    end

    committed_d = out_valid & ~m_axis_tready;

    idle_cnt_d = idle_cnt_q;
    if (in_hs || out_hs) begin
      idle_cnt_d = '0;
    end else if (hold_valid_q && !s_axis_tvalid && !committed_q && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    pkt_cnt_d = pkt_cnt_q;
    if (payload_hs) pkt_cnt_d = force_last ? '0 : pkt_cnt_q + CNT_W'(1);

    done_d = out_hs & out_last;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      pkt_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      committed_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      pkt_cnt_q    <= pkt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      committed_q  <= committed_d;
      done_q       <= done_d;
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign s_axis_tready = in_ready;
  assign pkt_done      = done_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Testbench for axis_pkt_framer: cycle table, hand-written corner sequences
// and randomized streams checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_pkt_framer;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = 8;
`ifdef AXIS_PKT_CHECKSUM_EN
  localparam int unsigned TRL = 1;
`else
  localparam int unsigned TRL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          pkt_done;

  axis_pkt_framer #(
    .DATA_WIDTH   (DW),
    .MAX_PKT_LEN  (MAXL),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_done      (pkt_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int unsigned   c;
  } beat_t;

  beat_t         rx_q[$];
  beat_t         exp_q[$];
  int unsigned   acc_q[$];
  logic [DW-1:0] in_b[$];
  int unsigned   in_gap[$];
  int            done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Mid-cycle monitor: records handshakes, checks AXI stability and pkt_done timing.
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_d = '0;
  logic          stall_l = 1'b0;
  logic          lasths_p = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p  = 1'b0;
      lasths_p = 1'b0;
    end else begin
      check("pkt_done_pulse", pkt_done, lasths_p);
      if (pkt_done) done_cnt++;
      if (stall_p) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, stall_d);
        check("stall_tlast", m_axis_tlast, stall_l);
      end
      if (s_axis_tvalid && s_axis_tready) acc_q.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready)
        rx_q.push_back('{d: m_axis_tdata, l: m_axis_tlast, c: cyc});
      lasths_p = m_axis_tvalid & m_axis_tready & m_axis_tlast;
      stall_p  = m_axis_tvalid & ~m_axis_tready;
      stall_d  = m_axis_tdata;
      stall_l  = m_axis_tlast;
    end
  end

  // Reference model: bytes are grouped into packets of at most MAXL; a packet
  // also ends when the source pauses TMO or more cycles after a byte, or at
  // the end of the stream. Checksum builds append the XOR of the payload.
  function automatic void build_exp();
    int unsigned   cnt = 0;
    logic [DW-1:0] x = '0;
    bit            close;
    exp_q.delete();
    for (int i = 0; i < in_b.size(); i++) begin
      cnt++;
      x ^= in_b[i];
      close = (cnt == MAXL) || (i == in_b.size() - 1);
      if (!close && in_gap[i+1] >= TMO) close = 1'b1;
`ifdef AXIS_PKT_CHECKSUM_EN
      exp_q.push_back('{d: in_b[i], l: 1'b0, c: 0});
      if (close) exp_q.push_back('{d: x, l: 1'b1, c: 0});
`else
      exp_q.push_back('{d: in_b[i], l: close, c: 0});
`endif
      if (close) begin
        cnt = 0;
        x   = '0;
      end
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives in_b with in_gap idle cycles before each byte; sink ready is
  // either always 1 or a coin flip per cycle. Then compares against the model.
  task automatic run_stream(input bit rnd_rdy, input string nm);
    bit          stop;
    bit          hs;
    int unsigned k;
    int unsigned n;
    rx_q.delete();
    acc_q.delete();
    done_cnt = 0;
    build_exp();
    stop = 1'b0;
    fork
      begin
        while (!stop) begin
          m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          @(posedge clk);
          #1;
        end
      end
      begin
        foreach (in_b[i]) begin
          repeat (in_gap[i]) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
          end
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = in_b[i];
          k = 0;
          do begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            k++;
          end while (!hs && k < 1000);
          if (!hs) check({nm, "_input_accept_timeout"}, 0, 1);
        end
        s_axis_tvalid = 1'b0;
        k = 0;
        while (rx_q.size() < exp_q.size() && k < 3000) begin
          @(posedge clk);
          #1;
          k++;
        end
        repeat (TMO + 4) @(posedge clk);
        #1;
        stop = 1'b1;
      end
    join
    m_axis_tready = 1'b1;
    check({nm, "_accepted"}, acc_q.size(), in_b.size());
    check({nm, "_beats"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].tdata", nm, i), rx_q[i].d, exp_q[i].d);
      check($sformatf("%s[%0d].tlast", nm, i), rx_q[i].l, exp_q[i].l);
    end
  endtask

  // The held last byte is first offered TMO cycles after its accept edge,
  // i.e. in cycle accept+1+TMO counting from the cycle the byte was presented.
  task automatic check_timeout(input string nm);
    int idx;
    idx = exp_q.size() - 1 - TRL;
    if (rx_q.size() > idx && acc_q.size() > 0 && idx >= 0)
      check(nm, rx_q[idx].c - acc_q[acc_q.size()-1], TMO + 1);
    else
      check({nm, "_missing"}, rx_q.size(), exp_q.size());
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          ev;
    logic          el;
    logic [DW-1:0] ed;
    logic          esr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int brk;
    int lim;

    // Cycle table: fill, stall, committed valid held against a dropped input.
    tbl[0] = '{sv: 1, sd: 8'hA1, mr: 1, ev: 0, el: 0, ed: 8'h00, esr: 1};
    tbl[1] = '{sv: 1, sd: 8'hB2, mr: 0, ev: 1, el: 0, ed: 8'hA1, esr: 0};
    tbl[2] = '{sv: 1, sd: 8'hB2, mr: 0, ev: 1, el: 0, ed: 8'hA1, esr: 0};
    tbl[3] = '{sv: 1, sd: 8'hB2, mr: 1, ev: 1, el: 0, ed: 8'hA1, esr: 1};
    tbl[4] = '{sv: 0, sd: 8'h00, mr: 1, ev: 0, el: 0, ed: 8'hB2, esr: 0};
    tbl[5] = '{sv: 0, sd: 8'h00, mr: 0, ev: 0, el: 0, ed: 8'hB2, esr: 0};
    tbl[6] = '{sv: 1, sd: 8'hC3, mr: 0, ev: 1, el: 0, ed: 8'hB2, esr: 0};
    tbl[7] = '{sv: 0, sd: 8'hC3, mr: 0, ev: 1, el: 0, ed: 8'hB2, esr: 0};
    tbl[8] = '{sv: 0, sd: 8'hC3, mr: 1, ev: 1, el: 0, ed: 8'hB2, esr: 1};
    tbl[9] = '{sv: 0, sd: 8'hC3, mr: 1, ev: 0, el: 0, ed: 8'hB2, esr: 1};

    // Reset values
    rst_n = 1'b0;
    #2;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_s_tready", s_axis_tready, 1);

    // Table-driven cycle vectors
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = tbl[i].sv;
      s_axis_tdata  = tbl[i].sd;
      m_axis_tready = tbl[i].mr;
      @(negedge clk);
      check($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].ev);
      check($sformatf("tbl%0d_tlast", i), m_axis_tlast, tbl[i].el);
      check($sformatf("tbl%0d_s_tready", i), s_axis_tready, tbl[i].esr);
      if (tbl[i].ev) check($sformatf("tbl%0d_tdata", i), m_axis_tdata, tbl[i].ed);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with a committed byte held
    do_reset();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5A;
    @(posedge clk);
    #1 s_axis_tdata = 8'h5B;
    @(posedge clk);
    #1 check("prereset_tvalid", m_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_tlast", m_axis_tlast, 0);
    check("async_rst_tdata", m_axis_tdata, 0);
    check("async_rst_s_tready", s_axis_tready, 1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    repeat (TMO + 6) @(posedge clk);
    #1;
    check("post_reset_no_beats", rx_q.size(), 0);
    check("post_reset_no_done", done_cnt, 0);

    // Continuous 40 bytes, sink always ready
    do_reset();
    in_b.delete();
    in_gap.delete();
    for (int i = 0; i < 40; i++) begin
      in_b.push_back(8'(i));
      in_gap.push_back(0);
    end
    run_stream(1'b0, "cont40");
    check("cont40_pkt_done_count", done_cnt, 3);
    brk = 0;
    lim = exp_q.size() - 2 - TRL;
    for (int k = 1; k <= lim; k++)
      if (rx_q.size() > k && rx_q[k].c != rx_q[k-1].c + 1) brk++;
    check("cont40_one_beat_per_cycle", brk, 0);
    check_timeout("cont40_timeout_latency");

    // Burst of three then idle
    do_reset();
    in_b = '{8'h00, 8'h01, 8'h02};
    in_gap = '{0, 0, 0};
    run_stream(1'b0, "burst3");
    check_timeout("burst3_timeout_latency");
    check("burst3_pkt_done_count", done_cnt, 1);

    // Next byte arrives in the very cycle the idle count expires
    do_reset();
    in_b.delete();
    in_gap.delete();
    for (int i = 0; i < 18; i++) begin
      in_b.push_back(8'hA0 + 8'(i));
      in_gap.push_back(i == 1 ? TMO : 0);
    end
    run_stream(1'b0, "tmo_edge");
    if (rx_q.size() > 0 && acc_q.size() > 1)
      check("tmo_edge_same_cycle", rx_q[0].c, acc_q[1]);
    else
      check("tmo_edge_missing", rx_q.size(), exp_q.size());
    check("tmo_edge_pkt_done_count", done_cnt, 3);

    // Short packet 01,02,04
    do_reset();
    in_b = '{8'h01, 8'h02, 8'h04};
    in_gap = '{0, 0, 0};
    run_stream(1'b0, "xor3");
`ifdef AXIS_PKT_CHECKSUM_EN
    check("xor3_trailer_value", rx_q.size() > 3 ? rx_q[3].d : 8'hxx, 8'h07);
`endif

    // Randomized: 200 bytes, short source gaps, 50% sink ready
    do_reset();
    in_b.delete();
    in_gap.delete();
    for (int i = 0; i < 200; i++) begin
      in_b.push_back(8'($urandom));
      in_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO - 1) : 0);
    end
    run_stream(1'b1, "rand200");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
